// File: rtl/warp_fetch_scheduler_pkg.sv
// Shared compute-unit definitions: warp lifecycle states and default-width
// helper types used by the fetch scheduler and its neighbours.
package warp_fetch_scheduler_pkg;

    localparam int unsigned CuNumWarps  = 8;
    localparam int unsigned CuWarpWidth = 32;
    localparam int unsigned CuPcWidth   = 32;
    localparam int unsigned CuWidWidth  = $clog2(CuNumWarps);

    typedef logic [CuWidWidth-1:0]  wid_t;
    typedef logic [CuPcWidth-1:0]   pc_t;
    typedef logic [CuWarpWidth-1:0] act_mask_t;

    typedef enum logic [1:0] {
        WARP_FREE    = 2'd0,
        WARP_READY   = 2'd1,
        WARP_WAITING = 2'd2
    } warp_state_e;

endpackage

// File: rtl/warp_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after the
// pointer, wrapping modulo N, wins.
module warp_fetch_scheduler_rr_arbiter #(
    parameter  int unsigned N    = 8,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_onehot_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        gnt_valid_o  = 1'b0;
        cand         = '0;
        for (int i = 0; i < int'(N); i++) begin
            // N is a power of two, so the index sum wraps naturally
            cand = ptr_i + IdxW'(i);
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_valid_o        = 1'b1;
                gnt_idx_o          = cand;
                gnt_onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// Per-warp fetch controller: tracks warp state/PC/mask, picks one eligible
// warp per cycle round-robin and holds it in a registered fetch slot.
module warp_fetch_scheduler
    import warp_fetch_scheduler_pkg::*;
#(
    parameter  int unsigned NumWarps  = CuNumWarps,
    parameter  int unsigned WarpWidth = CuWarpWidth,
    parameter  int unsigned PcWidth   = CuPcWidth,
    localparam int unsigned WidWidth  = $clog2(NumWarps)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_valid_i,
    output logic                 start_ready_o,
    input  logic [PcWidth-1:0]   start_pc_i,
    input  logic [WarpWidth-1:0] start_act_mask_i,
    input  logic [NumWarps-1:0]  ib_space_i,
    input  logic                 ic_ready_i,
    output logic                 fe_valid_o,
    output logic [PcWidth-1:0]   fe_pc_o,
    output logic [WarpWidth-1:0] fe_act_mask_o,
    output logic [WidWidth-1:0]  fe_warp_id_o,
    input  logic                 upd_valid_i,
    input  logic [WidWidth-1:0]  upd_warp_id_i,
    input  logic [PcWidth-1:0]   upd_pc_i,
    input  logic [WarpWidth-1:0] upd_act_mask_i,
    input  logic                 upd_finished_i,
    output logic [NumWarps-1:0]  warp_active_o,
    output logic                 idle_o
);

    warp_state_e          state_q [NumWarps];
    warp_state_e          state_d [NumWarps];
    logic [PcWidth-1:0]   pc_q    [NumWarps];
    logic [PcWidth-1:0]   pc_d    [NumWarps];
    logic [WarpWidth-1:0] mask_q  [NumWarps];
    logic [WarpWidth-1:0] mask_d  [NumWarps];

    logic [WidWidth-1:0]  rr_ptr_q, rr_ptr_d;
    logic                 fe_valid_q, fe_valid_d;
    logic [PcWidth-1:0]   fe_pc_q, fe_pc_d;
    logic [WarpWidth-1:0] fe_mask_q, fe_mask_d;
    logic [WidWidth-1:0]  fe_wid_q, fe_wid_d;

    logic [NumWarps-1:0]  free_vec;
    logic [NumWarps-1:0]  eligible;
    logic [WidWidth-1:0]  alloc_idx;
    logic                 start_fire;
    logic                 load_en;
    logic                 load_fire;
    logic                 upd_ok;

    logic [NumWarps-1:0]  gnt_onehot;
    logic [WidWidth-1:0]  gnt_idx;
    logic                 gnt_valid;

    always_comb begin
        free_vec  = '0;
        eligible  = '0;
        alloc_idx = '0;
        for (int w = NumWarps - 1; w >= 0; w--) begin
            free_vec[w] = (state_q[w] == WARP_FREE);
            eligible[w] = (state_q[w] == WARP_READY) && ib_space_i[w];
            if (state_q[w] == WARP_FREE) begin
                alloc_idx = WidWidth'(w);
            end
        end
    end

    warp_fetch_scheduler_rr_arbiter #(
        .N (NumWarps)
    ) u_rr_arbiter (
        .req_i        (eligible),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .gnt_valid_o  (gnt_valid)
    );

    assign start_ready_o = |free_vec;
    assign start_fire    = start_valid_i && start_ready_o;
    // The slot may refill whenever it is empty or being drained this cycle
    assign load_en       = !fe_valid_q || ic_ready_i;
    assign load_fire     = load_en && gnt_valid;
    assign upd_ok        = upd_valid_i && (state_q[upd_warp_id_i] == WARP_WAITING);

    always_comb begin
        for (int w = 0; w < int'(NumWarps); w++) begin
            state_d[w] = state_q[w];
            pc_d[w]    = pc_q[w];
            mask_d[w]  = mask_q[w];
            if (start_fire && (alloc_idx == WidWidth'(w))) begin
                state_d[w] = WARP_READY;
                pc_d[w]    = start_pc_i;
                mask_d[w]  = start_act_mask_i;
            end
            if (load_fire && gnt_onehot[w]) begin
                state_d[w] = WARP_WAITING;
            end
            if (upd_ok && (upd_warp_id_i == WidWidth'(w))) begin
                if (upd_finished_i) begin
                    state_d[w] = WARP_FREE;
                end else begin
                    state_d[w] = WARP_READY;
                    pc_d[w]    = upd_pc_i;
                    mask_d[w]  = upd_act_mask_i;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        fe_valid_d = fe_valid_q;
        fe_pc_d    = fe_pc_q;
        fe_mask_d  = fe_mask_q;
        fe_wid_d   = fe_wid_q;
        if (load_en) begin
            fe_valid_d = gnt_valid;
            if (gnt_valid) begin
                fe_pc_d   = pc_q[gnt_idx];
                fe_mask_d = mask_q[gnt_idx];
                fe_wid_d  = gnt_idx;
                rr_ptr_d  = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < int'(NumWarps); w++) begin
                state_q[w] <= WARP_FREE;
                pc_q[w]    <= '0;
                mask_q[w]  <= '0;
            end
            rr_ptr_q   <= '0;
            fe_valid_q <= 1'b0;
            fe_pc_q    <= '0;
            fe_mask_q  <= '0;
            fe_wid_q   <= '0;
        end else begin
            for (int w = 0; w < int'(NumWarps); w++) begin
                state_q[w] <= state_d[w];
                pc_q[w]    <= pc_d[w];
                mask_q[w]  <= mask_d[w];
            end
            rr_ptr_q   <= rr_ptr_d;
            fe_valid_q <= fe_valid_d;
            fe_pc_q    <= fe_pc_d;
            fe_mask_q  <= fe_mask_d;
            fe_wid_q   <= fe_wid_d;
        end
    end

    always_comb begin
        warp_active_o = '0;
        for (int w = 0; w < int'(NumWarps); w++) begin
            warp_active_o[w] = (state_q[w] != WARP_FREE);
        end
    end

    assign idle_o        = !(|warp_active_o) && !fe_valid_q;
    assign fe_valid_o    = fe_valid_q;
    assign fe_pc_o       = fe_pc_q;
    assign fe_act_mask_o = fe_mask_q;
    assign fe_warp_id_o  = fe_wid_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i && upd_valid_i) begin
            assert (state_q[upd_warp_id_i] == WARP_WAITING)
                else $error("update to warp %0d which is not waiting", upd_warp_id_i);
            assert (!(fe_valid_q && (fe_wid_q == upd_warp_id_i)))
                else $error("update to warp %0d while it sits in the fetch slot", upd_warp_id_i);
        end
    end
`endif

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// each cycle against a behavioural warp-table model.
module tb_warp_fetch_scheduler;

    localparam int NW = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_valid_i;
    logic        start_ready_o;
    logic [31:0] start_pc_i;
    logic [31:0] start_act_mask_i;
    logic [7:0]  ib_space_i;
    logic        ic_ready_i;
    logic        fe_valid_o;
    logic [31:0] fe_pc_o;
    logic [31:0] fe_act_mask_o;
    logic [2:0]  fe_warp_id_o;
    logic        upd_valid_i;
    logic [2:0]  upd_warp_id_i;
    logic [31:0] upd_pc_i;
    logic [31:0] upd_act_mask_i;
    logic        upd_finished_i;
    logic [7:0]  warp_active_o;
    logic        idle_o;

    always #5 clk = ~clk;

    warp_fetch_scheduler dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_valid_i    (start_valid_i),
        .start_ready_o    (start_ready_o),
        .start_pc_i       (start_pc_i),
        .start_act_mask_i (start_act_mask_i),
        .ib_space_i       (ib_space_i),
        .ic_ready_i       (ic_ready_i),
        .fe_valid_o       (fe_valid_o),
        .fe_pc_o          (fe_pc_o),
        .fe_act_mask_o    (fe_act_mask_o),
        .fe_warp_id_o     (fe_warp_id_o),
        .upd_valid_i      (upd_valid_i),
        .upd_warp_id_i    (upd_warp_id_i),
        .upd_pc_i         (upd_pc_i),
        .upd_act_mask_i   (upd_act_mask_i),
        .upd_finished_i   (upd_finished_i),
        .warp_active_o    (warp_active_o),
        .idle_o           (idle_o)
    );

    int checks = 0;
    int errors = 0;

    // model: 0 = free, 1 = ready, 2 = waiting
    int          m_state [NW];
    logic [31:0] m_pc    [NW];
    logic [31:0] m_mask  [NW];
    int          m_ptr;
    bit          m_fv;
    logic [31:0] m_fpc, m_fmask;
    int          m_fwid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_state[w] = 0;
            m_pc[w]    = 0;
            m_mask[w]  = 0;
        end
        m_ptr = 0; m_fv = 0; m_fpc = 0; m_fmask = 0; m_fwid = 0;
    endtask

    task automatic model_step();
        bit s_go, l_go, ld;
        int s_w, l_w;
        if (rst_i) begin
            model_reset();
            return;
        end
        s_go = 0; s_w = 0;
        if (start_valid_i)
            for (int w = NW - 1; w >= 0; w--)
                if (m_state[w] == 0) begin s_go = 1; s_w = w; end
        ld = !m_fv || ic_ready_i;
        l_go = 0; l_w = 0;
        if (ld)
            for (int i = 0; i < NW; i++) begin
                int c = (m_ptr + i) % NW;
                if (!l_go && m_state[c] == 1 && ib_space_i[c]) begin l_go = 1; l_w = c; end
            end
        if (upd_valid_i && m_state[upd_warp_id_i] == 2) begin
            if (upd_finished_i) m_state[upd_warp_id_i] = 0;
            else begin
                m_state[upd_warp_id_i] = 1;
                m_pc[upd_warp_id_i]    = upd_pc_i;
                m_mask[upd_warp_id_i]  = upd_act_mask_i;
            end
        end
        if (s_go) begin
            m_state[s_w] = 1;
            m_pc[s_w]    = start_pc_i;
            m_mask[s_w]  = start_act_mask_i;
        end
        if (ld) begin
            m_fv = l_go;
            if (l_go) begin
                m_state[l_w] = 2;
                m_fpc   = m_pc[l_w];
                m_fmask = m_mask[l_w];
                m_fwid  = l_w;
                m_ptr   = (l_w + 1) % NW;
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] act_exp;
        bit any_free;
        act_exp = 0; any_free = 0;
        for (int w = 0; w < NW; w++) begin
            act_exp[w] = (m_state[w] != 0);
            if (m_state[w] == 0) any_free = 1;
        end
        chk("start_ready", 64'(start_ready_o), 64'(any_free));
        chk("warp_active", 64'(warp_active_o), 64'(act_exp));
        chk("idle", 64'(idle_o), 64'(act_exp == 0 && !m_fv));
        chk("fe_valid", 64'(fe_valid_o), 64'(m_fv));
        if (m_fv) begin
            chk("fe_pc", 64'(fe_pc_o), 64'(m_fpc));
            chk("fe_mask", 64'(fe_act_mask_o), 64'(m_fmask));
            chk("fe_wid", 64'(fe_warp_id_o), 64'(m_fwid));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic quiet_inputs();
        start_valid_i = 0; start_pc_i = 0; start_act_mask_i = 0;
        ib_space_i = 0; ic_ready_i = 0;
        upd_valid_i = 0; upd_warp_id_i = 0; upd_pc_i = 0; upd_act_mask_i = 0; upd_finished_i = 0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst_i = 1;
        step();
        rst_i = 0;
    endtask

    task automatic launch(input int n, input logic [31:0] base);
        start_valid_i = 1;
        for (int k = 0; k < n; k++) begin
            start_pc_i = base + 32'(k * 4);
            start_act_mask_i = 32'hF0F0_0000 | 32'(k);
            step();
        end
        start_valid_i = 0;
    endtask

    // Drains the slot at full rate, updating each warp the cycle after its handshake.
    task automatic drain_with_updates(input int cycles, input bit finish, output int order[$]);
        bit pend;
        int pend_w;
        pend = 0; pend_w = 0;
        order.delete();
        for (int c = 0; c < cycles; c++) begin
            if (fe_valid_o) order.push_back(int'(fe_warp_id_o));
            upd_valid_i    = pend;
            upd_warp_id_i  = 3'(pend_w);
            upd_finished_i = finish;
            upd_pc_i       = 32'h300 + 32'(c * 16);
            upd_act_mask_i = 32'h0000_FFFF ^ 32'(c);
            pend   = m_fv;
            pend_w = m_fwid;
            step();
        end
        upd_valid_i = 0;
    endtask

    initial begin
        int order[$];
        logic [31:0] held_pc;
        int w;

        quiet_inputs();
        rst_i = 1;
        model_reset();
        step();
        step();
        chk("rst_fe_pc", 64'(fe_pc_o), 64'h0);
        chk("rst_fe_mask", 64'(fe_act_mask_o), 64'h0);
        chk("rst_fe_wid", 64'(fe_warp_id_o), 64'h0);
        chk("rst_fe_valid", 64'(fe_valid_o), 64'h0);
        chk("rst_idle", 64'(idle_o), 64'h1);
        chk("rst_start_ready", 64'(start_ready_o), 64'h1);
        rst_i = 0;

        // first launch latency
        ib_space_i = 8'hFF;
        start_valid_i = 1; start_pc_i = 32'h10; start_act_mask_i = 32'hFFFF_FFFF;
        step();
        start_valid_i = 0;
        chk("lat_t1_valid", 64'(fe_valid_o), 64'h0);
        step();
        chk("lat_t2_valid", 64'(fe_valid_o), 64'h1);
        chk("lat_t2_pc", 64'(fe_pc_o), 64'h10);
        chk("lat_t2_wid", 64'(fe_warp_id_o), 64'h0);
        ic_ready_i = 1;
        step();
        upd_valid_i = 1; upd_warp_id_i = 0; upd_finished_i = 1;
        step();
        upd_valid_i = 0;
        step();
        chk("lat_idle_after_finish", 64'(idle_o), 64'h1);

        // fill all slots, then a stalled ninth start
        do_reset();
        start_valid_i = 1;
        for (int k = 0; k < 9; k++) begin
            start_pc_i = 32'h100 + 32'(k * 4);
            start_act_mask_i = 32'h1 << k;
            step();
            if (k < 8) chk("fill_active", 64'(warp_active_o), 64'((1 << (k + 1)) - 1));
        end
        chk("fill_full_ready", 64'(start_ready_o), 64'h0);

        // backpressure with warp 2 presented; start still requested
        ic_ready_i = 0; ib_space_i = 8'h04;
        step();
        chk("bp_wid", 64'(fe_warp_id_o), 64'h2);
        chk("bp_pc", 64'(fe_pc_o), 64'h108);
        held_pc = fe_pc_o;
        ib_space_i = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_wid", 64'(fe_warp_id_o), 64'h2);
            chk("bp_hold_pc", 64'(fe_pc_o), 64'(held_pc));
        end
        ic_ready_i = 1;
        step();
        start_valid_i = 0;
        chk("bp_next_wid", 64'(fe_warp_id_o), 64'h3);
        chk("bp_next_pc", 64'(fe_pc_o), 64'h10C);
        rst_i = 1;
        step();
        rst_i = 0;
        chk("mid_rst_valid", 64'(fe_valid_o), 64'h0);

        // credit gating
        do_reset();
        launch(2, 32'h200);
        ib_space_i = 8'hFE; ic_ready_i = 1;
        step();
        chk("credit_wid1", 64'(fe_warp_id_o), 64'h1);
        ib_space_i = 8'hFF;
        step();
        chk("credit_wid0", 64'(fe_warp_id_o), 64'h0);
        chk("credit_pc0", 64'(fe_pc_o), 64'h200);

        // round-robin fairness with immediate refetch
        do_reset();
        launch(4, 32'h400);
        ib_space_i = 8'hFF; ic_ready_i = 1;
        drain_with_updates(12, 0, order);
        chk("rr_count", 64'(order.size() >= 8), 64'h1);
        for (int k = 0; k < 8 && k < order.size(); k++)
            chk("rr_order", 64'(order[k]), 64'(k % 4));

        // finish and reuse of a slot
        do_reset();
        launch(8, 32'h500);
        ib_space_i = 8'h08; ic_ready_i = 1;
        step();
        step();
        ib_space_i = 0;
        upd_valid_i = 1; upd_warp_id_i = 3; upd_finished_i = 1;
        start_valid_i = 1; start_pc_i = 32'h333; start_act_mask_i = 32'hABCD_0123;
        chk("reuse_ready_same_cycle", 64'(start_ready_o), 64'h0);
        step();
        upd_valid_i = 0;
        chk("reuse_freed", 64'(warp_active_o), 64'hF7);
        chk("reuse_ready_next", 64'(start_ready_o), 64'h1);
        step();
        start_valid_i = 0;
        chk("reuse_refilled", 64'(warp_active_o), 64'hFF);
        ib_space_i = 8'hFF; ic_ready_i = 1;
        drain_with_updates(24, 1, order);
        chk("reuse_all_issued", 64'(order.size()), 64'd8);
        chk("finish_all_idle", 64'(idle_o), 64'h1);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            start_valid_i = ($urandom_range(0, 2) == 0);
            start_pc_i = $urandom;
            start_act_mask_i = $urandom;
            ib_space_i = 8'($urandom);
            ic_ready_i = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, NW - 1);
            upd_valid_i = !rst_i && m_state[w] == 2 && !(m_fv && m_fwid == w)
                          && ($urandom_range(0, 1) == 1);
            upd_warp_id_i = 3'(w);
            upd_finished_i = ($urandom_range(0, 3) == 0);
            upd_pc_i = $urandom;
            upd_act_mask_i = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
